// File: rtl/middle_ram_pingpong_controller.sv
// Double-buffered frame RAM: writer fills one bank while the reader drains the other.
// Ports: write (iWren/col/row/data/FrameDone, oWrReady), read (iRden/col/row/FrameDone, oRddata/oRdvalid), status.
module middle_ram_pingpong_controller #(
  parameter int WIDTH_BITS  = 7,
  parameter int HEIGHT_BITS = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = WIDTH_BITS + HEIGHT_BITS
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   iWren,
  input  logic [WIDTH_BITS-1:0]  iWrcol,
  input  logic [HEIGHT_BITS-1:0] iWrrow,
  input  logic [DATA_WIDTH-1:0]  iWrdata,
  input  logic                   iWrFrameDone,
  output logic                   oWrReady,
  input  logic                   iRden,
  input  logic [WIDTH_BITS-1:0]  iRdcol,
  input  logic [HEIGHT_BITS-1:0] iRdrow,
  input  logic                   iRdFrameDone,
  output logic [DATA_WIDTH-1:0]  oRddata,
  output logic                   oRdvalid,
  output logic                   oRdBankValid,
  output logic                   oWrBank,
  output logic                   oSwapPulse,
  output logic [15:0]            oFrameCount,
  output logic [7:0]             oWrDropCount
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH + 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_WAIT_RD,
    S_WAIT_WR,
    S_SWAP
  } state_t;

  state_t state, state_nxt;
  logic   wr_ready;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_fire;
  logic                  rd_v1;
  logic [ADDR_WIDTH:0]   rd_a1;

  assign wr_addr  = {iWrrow, iWrcol};
  assign wr_fire  = iWren && wr_ready;
  assign oWrReady = wr_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_FILL;
    else          state <= state_nxt;
  end

  // Reader done is meaningless before the first frame exists.
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b1;
    unique case (state)
      S_FILL: begin
        if (iWrFrameDone && (iRdFrameDone || !oRdBankValid))
          state_nxt = S_SWAP;
        else if (iWrFrameDone)
          state_nxt = S_WAIT_RD;
        else if (iRdFrameDone && oRdBankValid)
          state_nxt = S_WAIT_WR;
      end
      S_WAIT_RD: begin
        wr_ready = 1'b0;
        if (iRdFrameDone) state_nxt = S_SWAP;
      end
      S_WAIT_WR: begin
        if (iWrFrameDone) state_nxt = S_SWAP;
      end
      S_SWAP: begin
        wr_ready  = 1'b0;
        state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      oWrBank      <= 1'b0;
      oRdBankValid <= 1'b0;
      oSwapPulse   <= 1'b0;
      oFrameCount  <= '0;
      oWrDropCount <= '0;
    end else begin
      oSwapPulse <= (state == S_SWAP);
      if (state == S_SWAP) begin
        oWrBank      <= ~oWrBank;
        oRdBankValid <= 1'b1;
        oFrameCount  <= oFrameCount + 16'd1;
      end
      if (iWren && !wr_ready && oWrDropCount != 8'hFF)
        oWrDropCount <= oWrDropCount + 8'd1;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_fire) mem[{oWrBank, wr_addr}] <= iWrdata;
  end

  // Bank is latched with the request, so a read in the swap cycle sees the old bank.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_v1    <= 1'b0;
      rd_a1    <= '0;
      oRdvalid <= 1'b0;
      oRddata  <= '0;
    end else begin
      rd_v1    <= iRden;
      oRdvalid <= rd_v1;
      if (iRden) rd_a1 <= {~oWrBank, iRdrow, iRdcol};
      if (rd_v1) oRddata <= mem[rd_a1];
    end
  end

endmodule

// File: doc/middle_ram_pingpong_controller.md
Name: middle_ram_pingpong_controller

Overview:
Parametrised double-buffered (ping-pong) successor to the single-bank intermediate-image RAM controller in the adaptive-thresholding pipeline. Two internal banks of 2^(WIDTH_BITS+HEIGHT_BITS) words each:
- the upstream stage writes a frame into one bank while the downstream stage reads the previous frame from the other;
- banks swap under a frame-done handshake.

Adds over the predecessor: configurable data width, registered read with a valid pipeline, swap state machine, write-lock back-pressure, frame and drop counters.

Parameters:
WIDTH_BITS, 7, log2 image width (128).
HEIGHT_BITS, 7, log2 image height (128).
DATA_WIDTH, 8, pixel word width.
ADDR_WIDTH, WIDTH_BITS+HEIGHT_BITS, derived bank address width; not overridden.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset_n  input  1  asynchronous active-low reset.
iWren  input  1  write request.
iWrcol  input  WIDTH_BITS  write X coordinate.
iWrrow  input  HEIGHT_BITS  write Y coordinate.
iWrdata  input  DATA_WIDTH  write pixel.
iWrFrameDone  input  1  one-cycle pulse: writer finished its frame.
oWrReady  output  1  writes accepted when high.
iRden  input  1  read request.
iRdcol  input  WIDTH_BITS  read X coordinate.
iRdrow  input  HEIGHT_BITS  read Y coordinate.
iRdFrameDone  input  1  one-cycle pulse: reader finished its frame.
oRddata  output  DATA_WIDTH  read pixel.
oRdvalid  output  1  oRddata valid this cycle.
oRdBankValid  output  1  read bank holds a completed frame.
oWrBank  output  1  index of bank currently written (read bank = ~oWrBank).
oSwapPulse  output  1  one-cycle pulse in the cycle after a swap.
oFrameCount  output  16  number of swaps since reset, wrapping.
oWrDropCount  output  8  writes dropped while locked, saturating at 255.

Behaviour:
- Address: addr = {row, col}, i.e. (row << WIDTH_BITS) + col. All coordinates are in range by construction.
- Reset (reset_n low, asynchronous): state S_FILL, oWrBank=0, oRdBankValid=0, oRdvalid=0, oRddata=0, oSwapPulse=0, oFrameCount=0, oWrDropCount=0, read pipeline cleared. RAM contents are not cleared. Reset mid-frame discards all pending handshake state.
- Write: when iWren && oWrReady, write iWrdata at addr into bank oWrBank on that edge.
  - iWren && !oWrReady: write discarded; oWrDropCount increments (saturating).
- Read: 2-cycle latency.
  - Cycle N: iRden sampled together with address and read bank (~oWrBank as of cycle N).
  - Cycle N+2: oRddata/oRdvalid=1.
  - Reads are always accepted, one per cycle, fully pipelined.
  - oRdvalid is 0 when no read was issued; oRddata holds its last value.
  - Data is undefined while oRdBankValid=0, but oRdvalid still asserts.
  - A read issued in the S_SWAP cycle uses the pre-swap bank.
- No same-bank read/write conflict is possible; writer and reader banks always differ.
- State machine:
  - S_FILL: oWrReady=1.
    - WrDone && (RdDone || !oRdBankValid) -> S_SWAP.
    - WrDone only -> S_WAIT_RD.
    - RdDone only -> S_WAIT_WR.
  - S_WAIT_RD: oWrReady=0 (writer locked). RdDone -> S_SWAP.
  - S_WAIT_WR: oWrReady=1. WrDone -> S_SWAP. A further RdDone is ignored.
  - S_SWAP: oWrReady=0 for one cycle.
    - Next edge: oWrBank toggles, oRdBankValid=1, oFrameCount+1, oSwapPulse=1 for one cycle, -> S_FILL.
    - Done pulses arriving in S_SWAP are ignored.
  - WrDone in S_WAIT_RD is ignored.
- While oRdBankValid=0 (first frame), iRdFrameDone is not required. iRdFrameDone pulses in S_FILL with oRdBankValid=0 are ignored; they do not enter S_WAIT_WR.
- oWrReady is combinational from state. All other outputs are registered.

Test Plan:
1. First frame: reset; write pixel (col=5,row=3)=0xA7 to bank 0 (addr 389); pulse iWrFrameDone -> S_SWAP next cycle, then oWrBank=1, oRdBankValid=1, oFrameCount=1, oSwapPulse high one cycle; read (5,3) -> oRddata=0xA7, oRdvalid two cycles after iRden.
2. Writer-first lock: in frame 2, pulse iWrFrameDone with no iRdFrameDone -> oWrReady=0; issue 300 writes -> oWrDropCount=255; bank-1 contents unchanged; pulse iRdFrameDone -> swap, oFrameCount=2, oWrReady=1.
3. Reader-first: pulse iRdFrameDone, hold writes for 10 cycles (oWrReady stays 1, no swap), then iWrFrameDone -> swap after 1 cycle.
4. Simultaneous done pulses in S_FILL with oRdBankValid=1 -> direct swap; no wait state entered.
5. Read pipeline: back-to-back iRden on 4 addresses holding 0x10,0x20,0x30,0x40 -> oRddata matches in order, oRdvalid high 4 consecutive cycles; a read issued in the S_SWAP cycle returns old-bank data.
6. Reset mid-operation: deassert reset_n during S_WAIT_RD with reads in flight -> all outputs at reset values immediately, oRdvalid=0, oWrBank=0, oFrameCount=0.
